// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port integer register file.
//
// After reset the array is walked once and every register is written to
// zero (CLEAR state); `ready` rises on the edge that writes the last
// register. The block then stays in RUN until the next reset.
//
// In RUN it provides:
//   * NWR write ports; the highest port index wins on an address collision.
//   * NRD combinational read ports, with optional same-cycle write-to-read
//     forwarding (BYPASS).
//   * A pending-write scoreboard. An issue sets the destination bit. A
//     write clears it. If both hit the same register in the same cycle, the
//     issue wins.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-low reset
//   run          global enable; 0 freezes writes and scoreboard updates
//   ready        1 once the clear sequence has finished
//   raddr        NRD read addresses, port i at [i*AW +: AW]
//   rdata        NRD read data words, combinational
//   rbusy        NRD flags, 1 = addressed register has a pending write
//   we           NWR write enables
//   waddr        NWR write addresses
//   wdata        NWR write data words
//   issue_valid  marks issue_addr as pending
//   issue_addr   destination register of the instruction being issued
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run,
  output logic                           ready,
  input  logic [NRD*$clog2(NREGS)-1:0]   raddr,
  output logic [NRD*XLEN-1:0]            rdata,
  output logic [NRD-1:0]                 rbusy,
  input  logic [NWR-1:0]                 we,
  input  logic [NWR*$clog2(NREGS)-1:0]   waddr,
  input  logic [NWR*XLEN-1:0]            wdata,
  input  logic                           issue_valid,
  input  logic [$clog2(NREGS)-1:0]       issue_addr
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             state_r;
  logic [AW-1:0]      clr_ptr_r;
  logic               ready_r;
  logic [XLEN-1:0]    mem_r [NREGS];
  logic [NREGS-1:0]   pending_r;
  logic [NREGS-1:0]   pending_nxt_s;
  logic [NWR-1:0]     wr_eff_s;
  logic               issue_eff_s;
  logic [AW-1:0]      rd_addr_s;
  logic [XLEN-1:0]    rd_val_s;
  logic               rd_busy_s;
  logic               rd_hit_s;

  assign ready = ready_r;

  // A write takes effect only in RUN with run high, and not to a hardwired zero.
  always_comb begin
    wr_eff_s = {NWR{1'b0}};
    for (int j = 0; j < NWR; j++) begin
      wr_eff_s[j] = we[j] && run && ready_r &&
                    !((ZERO_REG != 0) && (waddr[j*AW +: AW] == {AW{1'b0}}));
    end
  end

  // An issue marks its destination pending under the same gating as writes.
  always_comb begin
    issue_eff_s = issue_valid && run && ready_r &&
                  !((ZERO_REG != 0) && (issue_addr == {AW{1'b0}}));
  end

  // Clear/run sequencer with the registered ready flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_CLEAR;
      clr_ptr_r <= {AW{1'b0}};
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_ptr_r <= clr_ptr_r + AW'(1);
          if (clr_ptr_r == AW'(NREGS - 1)) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end else begin
            state_r <= ST_CLEAR;
            ready_r <= 1'b0;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          ready_r <= 1'b1;
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_ptr_r <= {AW{1'b0}};
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zero fill while clearing, port writes in RUN.
  // The array has no reset of its own; the clear walk initialises it.
  // Ports are applied in ascending order so the highest index lands last.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_r == ST_CLEAR) begin
        mem_r[clr_ptr_r] <= {XLEN{1'b0}};
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_eff_s[j]) begin
            mem_r[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Scoreboard next state: retiring writes clear bits first, then an issue
  // sets its bit, so a same-cycle issue overrides the retire.
  always_comb begin
    pending_nxt_s = pending_r;
    for (int j = 0; j < NWR; j++) begin
      if (wr_eff_s[j]) begin
        pending_nxt_s[waddr[j*AW +: AW]] = 1'b0;
      end else begin
        pending_nxt_s = pending_nxt_s;
      end
    end
    if (issue_eff_s) begin
      pending_nxt_s[issue_addr] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_r <= {NREGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Read ports.
  // Forwarding scans the write ports in ascending order so the highest
  // index wins. Zero-register and not-ready masking are applied last.
  always_comb begin
    rdata     = {(NRD*XLEN){1'b0}};
    rbusy     = {NRD{1'b0}};
    rd_addr_s = {AW{1'b0}};
    rd_val_s  = {XLEN{1'b0}};
    rd_busy_s = 1'b0;
    rd_hit_s  = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rd_addr_s = raddr[i*AW +: AW];
      rd_val_s  = mem_r[rd_addr_s];
      rd_busy_s = pending_r[rd_addr_s];
      for (int j = 0; j < NWR; j++) begin
        rd_hit_s  = (BYPASS != 0) && wr_eff_s[j] && (waddr[j*AW +: AW] == rd_addr_s);
        rd_val_s  = rd_hit_s ? wdata[j*XLEN +: XLEN] : rd_val_s;
        rd_busy_s = rd_hit_s ? 1'b0 : rd_busy_s;
      end
      if (((ZERO_REG != 0) && (rd_addr_s == {AW{1'b0}})) || !ready_r) begin
        rd_val_s  = {XLEN{1'b0}};
        rd_busy_s = 1'b0;
      end else begin
        rd_val_s  = rd_val_s;
        rd_busy_s = rd_busy_s;
      end
      rdata[i*XLEN +: XLEN] = rd_val_s;
      rbusy[i]              = rd_busy_s;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp (NWR=2, other parameters at their defaults).
// A behavioural model (arrays plus an edge counter) predicts ready, rdata
// and rbusy. Directed scenarios are followed by a randomized phase.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 run;
  logic                 ready;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rbusy;
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    waddr;
  logic [NWR*XLEN-1:0]  wdata;
  logic                 issue_valid;
  logic [AW-1:0]        issue_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [XLEN-1:0] m_mem  [NREGS];
  bit              m_pend [NREGS];
  bit              m_ready;
  int              m_cnt;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .ready(ready),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_addr(issue_addr)
  );

  always #5 clk = ~clk;

  // Does write port j take effect this cycle?
  function automatic bit m_eff(int j);
    return m_ready && run && we[j] && (waddr[j*AW +: AW] != 5'd0);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(int p);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = raddr[p*AW +: AW];
    if (!m_ready || a == 5'd0) return 32'd0;
    v = m_mem[a];
    for (int j = 0; j < NWR; j++)
      if (m_eff(j) && waddr[j*AW +: AW] == a) v = wdata[j*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_busy(int p);
    logic [AW-1:0] a;
    a = raddr[p*AW +: AW];
    if (!m_ready || a == 5'd0) return 1'b0;
    for (int j = 0; j < NWR; j++)
      if (m_eff(j) && waddr[j*AW +: AW] == a) return 1'b0;
    return m_pend[a];
  endfunction

  // One clock edge: advance the model using the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_cnt   = 0;
      m_ready = 1'b0;
      for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NREGS) begin
        m_ready = 1'b1;
        for (int r = 0; r < NREGS; r++) m_mem[r] = 32'd0;
      end
    end else if (run) begin
      for (int j = 0; j < NWR; j++) begin
        if (m_eff(j)) begin
          m_mem[waddr[j*AW +: AW]]  = wdata[j*XLEN +: XLEN];
          m_pend[waddr[j*AW +: AW]] = 1'b0;
        end
      end
      if (issue_valid && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 2'b00; waddr = 10'd0; wdata = 64'd0;
    issue_valid = 1'b0; issue_addr = 5'd0; raddr = 10'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; idle_inputs();
    tick(); tick();
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    reset = 1'b1;
    for (int k = 1; k <= NREGS; k++) begin
      tick();
      n_checks++;
      if (ready !== (k == NREGS)) begin
        n_fail++; $display("FAIL clear_ready edge %0d: got %b expected %b", k, ready, (k == NREGS));
      end
    end
    for (int a = 0; a < NREGS; a++) begin
      raddr = {a[4:0], a[4:0]};
      #1;
      n_checks++;
      if (rdata !== 64'd0 || rbusy !== 2'b00) begin
        n_fail++; $display("FAIL clear_zero r%0d: got %h/%b expected 0/00", a, rdata, rbusy);
      end
    end
    run = 1'b1;
  endtask

  task automatic test_write_read();
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF}; raddr = {5'd5, 5'd5};
    #1;
    n_checks++;
    if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL bypass_r5: got %h expected deadbeef x2", rdata);
    end
    tick();
    we = 2'b00;
    #1;
    n_checks++;
    if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL read_r5: got %h expected deadbeef x2", rdata);
    end
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'h1234}; raddr = 10'd0;
    #1;
    n_checks++;
    if (rdata !== 64'd0) begin n_fail++; $display("FAIL r0_bypass: got %h expected 0", rdata); end
    tick();
    we = 2'b00;
    #1;
    n_checks++;
    if (rdata !== 64'd0) begin n_fail++; $display("FAIL r0_write: got %h expected 0", rdata); end
  endtask

  task automatic test_dual_write();
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (rdata !== {32'h22, 32'h22}) begin n_fail++; $display("FAIL dual_bypass: got %h expected 22 x2", rdata); end
    tick();
    we = 2'b00;
    #1;
    n_checks++;
    if (rdata !== {32'h22, 32'h22}) begin n_fail++; $display("FAIL dual_write: got %h expected 22 x2", rdata); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_addr = 5'd3; raddr = {5'd0, 5'd3};
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL issue_same_cycle: got %b expected 0", rbusy[0]); end
    tick();
    issue_valid = 1'b0;
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL issue_r3: got %b expected 1", rbusy[0]); end
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h55};
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h55) begin
      n_fail++; $display("FAIL retire_bypass: got %b/%h expected 0/55", rbusy[0], rdata[31:0]);
    end
    tick();
    we = 2'b00;
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h55) begin
      n_fail++; $display("FAIL retire_r3: got %b/%h expected 0/55", rbusy[0], rdata[31:0]);
    end
    we = 2'b01; wdata = {32'd0, 32'h66}; issue_valid = 1'b1; issue_addr = 5'd3;
    tick();
    we = 2'b00; issue_valid = 1'b0;
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b1 || rdata[31:0] !== 32'h66) begin
      n_fail++; $display("FAIL issue_and_retire: got %b/%h expected 1/66", rbusy[0], rdata[31:0]);
    end
    issue_valid = 1'b1; issue_addr = 5'd0; raddr = {5'd0, 5'd0};
    tick();
    issue_valid = 1'b0;
    #1;
    n_checks++;
    if (rbusy !== 2'b00) begin n_fail++; $display("FAIL issue_r0: got %b expected 00", rbusy); end
  endtask

  task automatic test_run_freeze();
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'h99};
    tick();
    run = 1'b0; wdata = {32'd0, 32'hAAAA}; issue_valid = 1'b1; issue_addr = 5'd9; raddr = {5'd9, 5'd9};
    #1;
    n_checks++;
    if (rdata[31:0] !== 32'h99 || rbusy[0] !== 1'b0) begin
      n_fail++; $display("FAIL freeze_same_cycle: got %h/%b expected 99/0", rdata[31:0], rbusy[0]);
    end
    tick();
    we = 2'b00; issue_valid = 1'b0;
    #1;
    n_checks++;
    if (rdata[31:0] !== 32'h99 || rbusy[0] !== 1'b0) begin
      n_fail++; $display("FAIL freeze_r9: got %h/%b expected 99/0", rdata[31:0], rbusy[0]);
    end
    run = 1'b1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      run         = ($urandom_range(0, 7) != 0);
      we          = 2'($urandom);
      waddr       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, (it % 4 == 0) ? 31 : 7))};
      wdata       = {32'($urandom), 32'($urandom)};
      issue_valid = 1'($urandom);
      issue_addr  = 5'($urandom_range(0, 7));
      raddr       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int p = 0; p < NRD; p++) begin
        n_checks++;
        if (rdata[p*XLEN +: XLEN] !== exp_data(p) || rbusy[p] !== exp_busy(p)) begin
          n_fail++;
          $display("FAIL rand it %0d port %0d: got %h/%b expected %h/%b",
                   it, p, rdata[p*XLEN +: XLEN], rbusy[p], exp_data(p), exp_busy(p));
        end
      end
      tick();
    end
    idle_inputs();
    run = 1'b1;
  endtask

  task automatic test_reset_in_run();
    issue_valid = 1'b1; issue_addr = 5'd4; raddr = {5'd4, 5'd4};
    tick();
    issue_valid = 1'b0;
    #1;
    n_checks++;
    if (rbusy !== 2'b11) begin n_fail++; $display("FAIL pend_r4: got %b expected 11", rbusy); end
    reset = 1'b0;
    tick();
    n_checks++;
    if (rbusy !== 2'b00 || ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_run: got %b/%b expected 00/0", rbusy, ready);
    end
  endtask

  task automatic test_reset_mid_clear();
    int k;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    k = 0;
    while (ready !== 1'b1 && k < 3 * NREGS) begin
      tick();
      k++;
    end
    n_checks++;
    if (k !== NREGS) begin n_fail++; $display("FAIL restart_clear: got %0d edges expected %0d", k, NREGS); end
    raddr = {5'd9, 5'd5};
    #1;
    n_checks++;
    if (rdata !== 64'd0 || rbusy !== 2'b00) begin
      n_fail++; $display("FAIL recleared: got %h/%b expected 0/00", rdata, rbusy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dual_write();
    test_scoreboard();
    test_run_freeze();
    test_random();
    test_reset_in_run();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the core; next generation of the single-write, two-read register file.
- Adds configurable width/depth/port counts, hardware zero-initialisation after reset, write-to-read bypass and a per-register pending-write scoreboard.
- Sits between decode (read ports, issue/scoreboard) and writeback (write ports).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers (power of 2, >=2); AW = $clog2(NREGS) is a localparam.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.
- BYPASS, 1, when 1 same-cycle write data is forwarded to read ports.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- run  in  1  global enable; 0 freezes writes and scoreboard updates
- ready  out  1  1 once the clear sequence has finished
- raddr  in  NRD*AW  read addresses; port i is bits [i*AW +: AW]
- rdata  out  NRD*XLEN  read data, combinational
- rbusy  out  NRD  1 = register at raddr[i] has a pending write not yet satisfied
- we  in  NWR  write enables
- waddr  in  NWR*AW  write addresses
- wdata  in  NWR*XLEN  write data
- issue_valid  in  1  marks issue_addr as pending
- issue_addr  in  AW  destination register of the instruction being issued

Behaviour:
- Reset:
  - Sampled at posedge clk; reset==0 has priority over everything.
  - Next state: state=CLEAR, clr_ptr=0, ready=0, all pending bits=0.
  - Memory contents are not reset directly.
- FSM, states CLEAR and RUN:
  - CLEAR, each cycle with reset==1: mem[clr_ptr]<=0, clr_ptr<=clr_ptr+1. Runs regardless of run.
  - When clr_ptr==NREGS-1, the write of that cycle happens and state becomes RUN with ready=1 at the same edge.
  - ready therefore rises exactly NREGS clock edges after the first edge with reset==1.
  - RUN is held until reset.
  - Reset asserted mid-CLEAR restarts the sequence from 0.
- While ready==0:
  - rdata=0 and rbusy=0 on all ports.
  - we and issue_valid are ignored.
- Writes (RUN, run==1), at posedge:
  - For each port with we[j]==1, mem[waddr[j]]<=wdata[j].
  - If ZERO_REG==1, writes to address 0 are dropped.
  - Several ports writing the same address in one cycle: the highest port index wins.
  - run==0: no memory or scoreboard change; reads stay valid.
- Reads (RUN), combinational:
  - rdata[i]=mem[raddr[i]].
  - ZERO_REG==1 and raddr[i]==0 gives 0.
  - BYPASS==1 and a write effective this cycle (we, run, ready, not dropped) to raddr[i]: rdata[i]=wdata of the highest-index matching port.
  - BYPASS==0: the old value is returned until the next cycle.
- Scoreboard: pending[NREGS], registered.
  - Set: issue_valid && run && ready && !(ZERO_REG && issue_addr==0) sets pending[issue_addr].
  - Clear: any effective write to address a clears pending[a].
  - Set and clear of the same address in the same cycle: set wins (new producer issued as old one retires).
  - Issue to an already-pending register keeps it pending; no counting.
- rbusy[i]=pending[raddr[i]], except 0 when BYPASS==1 and an effective write to raddr[i] occurs this cycle. Always 0 for address 0 when ZERO_REG==1.
- Latency: write visible to a read next cycle (same cycle with BYPASS); pending visible next cycle.

Test Plan:
- Release reset with NREGS=32, run=0 -> ready==0 for 31 edges after release, ready==1 after the 32nd; reading all addresses returns 0.
- Write 0xDEADBEEF to r5 via port 0, read r5 on both ports next cycle -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
- NWR=2, both ports write r7 (0x11 on port 0, 0x22 on port 1) -> r7==0x22. With BYPASS=1, same-cycle read of r7 -> 0x22.
- issue_valid with addr=3 -> rbusy for r3 is 1 next cycle. Write r3=0x55 -> rbusy 0 in the write cycle (BYPASS=1) and stays 0. Issue and write r3 in the same cycle -> remains pending.
- run=0 with we=1 to r9 and issue_valid to r9 -> r9 value and pending bit unchanged.
- Assert reset during CLEAR at clr_ptr=10, then release -> ready takes a full NREGS cycles again. Assert reset in RUN with r4 pending -> rbusy 0 and ready 0 after the next edge.
